ecdsa_axil_csr_slave: RTL and testbench

AXI4-Lite responder that implements the ECDSA accelerator control/status register file. It sits between the PS-side CSR bus (s_axi_csrs_*) and the ECDSA core. It holds the command word, the input/output address-table bases and the argument counts. It generates the core start pulse and captures core completion for software polling.

---
 rtl/ecdsa_axil_csr_slave_if.sv | 34 +++
 rtl/ecdsa_axil_csr_slave.sv | 256 +++++++++++++++++++++++++
 tb/tb_ecdsa_axil_csr_slave.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecdsa_axil_csr_slave_if.sv
// AXI4-Lite CSR bus bundle between the PS-side master and the ECDSA CSR block.
// Only the channels a register-file responder needs are included (no PROT/IDs).
interface ecdsa_axil_csr_slave_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/ecdsa_axil_csr_slave.sv
// ECDSA accelerator CSR file behind an AXI4-Lite responder: command word, address
// tables, argument counts, core start pulse generation and done-flag capture.
module ecdsa_axil_csr_slave #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       resetn,
   ecdsa_axil_csr_slave_if.slave      s_axi_csrs,
   input  logic                       core_done,
   input  logic                       core_busy,
   output logic [DATA_W-1:0]          command,
   output logic [DATA_W-1:0]          addr_table_base_i,
   output logic [DATA_W-1:0]          argc_i,
   output logic [DATA_W-1:0]          addr_table_base_o,
   output logic [DATA_W-1:0]          argc_o,
   output logic                       start
);

   localparam int STRB_W = DATA_W / 8;
   localparam int WA_W   = ADDR_W - 2;

   localparam logic [0:0] W_IDLE = 1'b0;
   localparam logic [0:0] W_RESP = 1'b1;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [2:0] IDX_CMD    = 3'd0;
   localparam logic [2:0] IDX_BASE_I = 3'd1;
   localparam logic [2:0] IDX_ARGC_I = 3'd2;
   localparam logic [2:0] IDX_BASE_O = 3'd3;
   localparam logic [2:0] IDX_ARGC_O = 3'd4;

   // Register file
   logic [DATA_W-1:0] r_command;
   logic [DATA_W-1:0] r_base_i;
   logic [DATA_W-1:0] r_argc_i;
   logic [DATA_W-1:0] r_base_o;
   logic [DATA_W-1:0] r_argc_o;
   logic              r_done_flag;
   logic              r_start;

   // Write channel state
   logic [0:0]        r_wstate;
   logic              r_awready;
   logic              r_wready;
   logic              r_aw_latched;
   logic              r_w_latched;
   logic [WA_W-1:0]   r_awaddr;
   logic [DATA_W-1:0] r_wdata;
   logic [STRB_W-1:0] r_wstrb;
   logic              r_bvalid;
   logic [1:0]        r_bresp;

   // Read channel state
   logic [0:0]        r_rstate;
   logic              r_arready;
   logic              r_rvalid;
   logic [1:0]        r_rresp;
   logic [DATA_W-1:0] r_rdata;

   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_aw_have;
   logic              w_w_have;
   logic              w_commit;
   logic [WA_W-1:0]   w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic [STRB_W-1:0] w_wstrb;
   logic              w_wmapped;
   logic [2:0]        w_widx;
   logic [DATA_W-1:0] w_cmd_new;
   logic              w_cmd_wr;
   logic              w_start_cond;
   logic              w_ar_hs;
   logic [WA_W-1:0]   w_raddr;
   logic              w_rmapped;
   logic [DATA_W-1:0] w_rsel;
   logic              w_unused_addr_lsbs;

   // Byte lanes below the word offset never take part in decode.
   assign w_unused_addr_lsbs = &{1'b0, s_axi_csrs.awaddr[1:0], s_axi_csrs.araddr[1:0]};

   function automatic logic addr_mapped(input logic [WA_W-1:0] wa);
      return (wa[WA_W-1:3] == '0) && (wa[2:0] <= IDX_ARGC_O);
   endfunction

   function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] merged;
      merged = old_v;
      for (int i = 0; i < STRB_W; i++) begin
         if (strb[i]) merged[8*i +: 8] = new_v[8*i +: 8];
      end
      return merged;
   endfunction

   // ---------------------------------------------------------------- write path
   assign w_aw_hs   = s_axi_csrs.awvalid & r_awready;
   assign w_w_hs    = s_axi_csrs.wvalid  & r_wready;
   assign w_aw_have = r_aw_latched | w_aw_hs;
   assign w_w_have  = r_w_latched  | w_w_hs;
   assign w_commit  = (r_wstate == W_IDLE) & w_aw_have & w_w_have;

   // A half already latched wins; the other half comes straight off the bus.
   assign w_waddr   = r_aw_latched ? r_awaddr : s_axi_csrs.awaddr[ADDR_W-1:2];
   assign w_wdata   = r_w_latched  ? r_wdata  : s_axi_csrs.wdata;
   assign w_wstrb   = r_w_latched  ? r_wstrb  : s_axi_csrs.wstrb;
   assign w_wmapped = addr_mapped(w_waddr);
   assign w_widx    = w_waddr[2:0];

   assign w_cmd_new    = apply_strb(r_command, w_wdata, w_wstrb);
   assign w_cmd_wr     = w_commit & w_wmapped & (w_widx == IDX_CMD);
   assign w_start_cond = w_cmd_new[0] & ~r_command[0];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wstate     <= W_IDLE;
         r_awready    <= 1'b0;
         r_wready     <= 1'b0;
         r_aw_latched <= 1'b0;
         r_w_latched  <= 1'b0;
         r_awaddr     <= '0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_bvalid     <= 1'b0;
         r_bresp      <= RESP_OKAY;
      end else if (r_wstate == W_IDLE) begin
         if (w_commit) begin
            r_wstate     <= W_RESP;
            r_bvalid     <= 1'b1;
            r_bresp      <= w_wmapped ? RESP_OKAY : RESP_SLVERR;
            r_aw_latched <= 1'b0;
            r_w_latched  <= 1'b0;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
         end else begin
            // NOTE: state is updated with <= so every branch sees the pre-edge values.
            if (w_aw_hs) begin
               r_aw_latched <= 1'b1;
               r_awaddr     <= s_axi_csrs.awaddr[ADDR_W-1:2];
            end
            if (w_w_hs) begin
               r_w_latched <= 1'b1;
               r_wdata     <= s_axi_csrs.wdata;
               r_wstrb     <= s_axi_csrs.wstrb;
            end
            r_awready <= ~w_aw_have;
            r_wready  <= ~w_w_have;
         end
      end else if (s_axi_csrs.bready) begin
         r_wstate  <= W_IDLE;
         r_bvalid  <= 1'b0;
         r_awready <= 1'b1;
         r_wready  <= 1'b1;
      end
   end

   // -------------------------------------------------------------- register file
   always_ff @(posedge clk) begin
      if (!resetn) begin
         // NOTE: these are control registers the core acts on, so each one is reset.
         r_command   <= '0;
         r_base_i    <= '0;
         r_argc_i    <= '0;
         r_base_o    <= '0;
         r_argc_o    <= '0;
         r_done_flag <= 1'b0;
         r_start     <= 1'b0;
      end else begin
         r_start <= w_cmd_wr & w_start_cond;

         // Completion from the core outranks a clearing COMMAND write.
         if (core_done) begin
            r_done_flag <= 1'b1;
         end else if (w_cmd_wr && (!w_cmd_new[0] || w_start_cond)) begin
            r_done_flag <= 1'b0;
         end

         if (w_commit && w_wmapped) begin
            case (w_widx)
               IDX_CMD:    r_command <= w_cmd_new;
               IDX_BASE_I: r_base_i  <= apply_strb(r_base_i, w_wdata, w_wstrb);
               IDX_ARGC_I: r_argc_i  <= apply_strb(r_argc_i, w_wdata, w_wstrb);
               IDX_BASE_O: r_base_o  <= apply_strb(r_base_o, w_wdata, w_wstrb);
               IDX_ARGC_O: r_argc_o  <= apply_strb(r_argc_o, w_wdata, w_wstrb);
               default:    ;
            endcase
         end
      end
   end

   // ----------------------------------------------------------------- read path
   assign w_ar_hs   = s_axi_csrs.arvalid & r_arready;
   assign w_raddr   = s_axi_csrs.araddr[ADDR_W-1:2];
   assign w_rmapped = addr_mapped(w_raddr);

   always_comb begin
      // NOTE: default first so no path through the case leaves w_rsel unassigned.
      w_rsel = '0;
      case (w_raddr[2:0])
         IDX_CMD:    w_rsel = {{(DATA_W-2){1'b0}}, core_busy, r_done_flag};
         IDX_BASE_I: w_rsel = r_base_i;
         IDX_ARGC_I: w_rsel = r_argc_i;
         IDX_BASE_O: w_rsel = r_base_o;
         IDX_ARGC_O: w_rsel = r_argc_o;
         default:    w_rsel = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= '0;
      end else if (r_rstate == R_IDLE) begin
         if (w_ar_hs) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rmapped ? w_rsel : '0;
            r_rresp   <= w_rmapped ? RESP_OKAY : RESP_SLVERR;
         end else begin
            r_arready <= 1'b1;
         end
      end else if (s_axi_csrs.rready) begin
         r_rstate  <= R_IDLE;
         r_rvalid  <= 1'b0;
         r_arready <= 1'b1;
      end
   end

   // ------------------------------------------------------------------- outputs
   assign s_axi_csrs.awready = r_awready;
   assign s_axi_csrs.wready  = r_wready;
   assign s_axi_csrs.bvalid  = r_bvalid;
   assign s_axi_csrs.bresp   = r_bresp;
   assign s_axi_csrs.arready = r_arready;
   assign s_axi_csrs.rvalid  = r_rvalid;
   assign s_axi_csrs.rresp   = r_rresp;
   assign s_axi_csrs.rdata   = r_rdata;

   assign command           = r_command;
   assign addr_table_base_i = r_base_i;
   assign argc_i            = r_argc_i;
   assign addr_table_base_o = r_base_o;
   assign argc_o            = r_argc_o;
   assign start             = r_start;

endmodule

// File: tb/tb_ecdsa_axil_csr_slave.sv
// Directed bench for the ECDSA CSR slave: issue tasks push expected B/R responses,
// a negedge monitor pops and compares them on each handshake.
module tb_ecdsa_axil_csr_slave;

   logic        clk = 1'b0;
   logic        resetn;
   logic        core_done;
   logic        core_busy;
   logic [31:0] command;
   logic [31:0] addr_table_base_i;
   logic [31:0] argc_i;
   logic [31:0] addr_table_base_o;
   logic [31:0] argc_o;
   logic        start;

   int n_vec = 0;
   int n_err = 0;
   int start_cnt = 0;

   logic [1:0]  b_q[$];
   logic [33:0] r_q[$];

   ecdsa_axil_csr_slave_if #(.ADDR_W(12), .DATA_W(32)) axi ();

   ecdsa_axil_csr_slave #(.ADDR_W(12), .DATA_W(32)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .s_axi_csrs        (axi.slave),
      .core_done         (core_done),
      .core_busy         (core_busy),
      .command           (command),
      .addr_table_base_i (addr_table_base_i),
      .argc_i            (argc_i),
      .addr_table_base_o (addr_table_base_o),
      .argc_o            (argc_o),
      .start             (start)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: one pop per B or R handshake.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (axi.bvalid && axi.bready) begin
            if (b_q.size() == 0) check("unexpected bvalid", {30'b0, axi.bresp}, 32'hFFFF_FFFF);
            else check("bresp", {30'b0, axi.bresp}, {30'b0, b_q.pop_front()});
         end
         if (axi.rvalid && axi.rready) begin
            if (r_q.size() == 0) begin
               check("unexpected rvalid", axi.rdata, 32'hFFFF_FFFF);
            end else begin
               logic [33:0] e;
               e = r_q.pop_front();
               check("rdata", axi.rdata, e[33:2]);
               check("rresp", {30'b0, axi.rresp}, {30'b0, e[1:0]});
            end
         end
      end
      if (start === 1'b1) start_cnt++;
   end

   task automatic wait_b();
      bit hs = 1'b0;
      int cnt = 0;
      while (!hs && cnt < 30) begin
         @(negedge clk);
         hs = axi.bvalid && axi.bready;
         @(posedge clk); #1;
         cnt++;
      end
      check("b handshake", {31'b0, hs}, 32'd1);
   endtask

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er, input int w_lead, input bit hold_b);
      bit aw_done = 1'b0;
      bit w_done  = 1'b0;
      bit aw_hs, w_hs;
      int cnt = 0;
      b_q.push_back(er);
      axi.awaddr  = a;
      axi.wdata   = d;
      axi.wstrb   = s;
      axi.wvalid  = 1'b1;
      axi.awvalid = (w_lead == 0);
      if (hold_b) axi.bready = 1'b0;
      while (!(aw_done && w_done) && cnt < 30) begin
         @(negedge clk);
         aw_hs = axi.awvalid && axi.awready;
         w_hs  = axi.wvalid && axi.wready;
         @(posedge clk); #1;
         cnt++;
         if (aw_hs) begin aw_done = 1'b1; axi.awvalid = 1'b0; end
         if (w_hs)  begin w_done  = 1'b1; axi.wvalid  = 1'b0; end
         if (cnt == w_lead && !aw_done) axi.awvalid = 1'b1;
      end
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      check("aw/w accepted", {31'b0, aw_done && w_done}, 32'd1);
      if (!hold_b) wait_b();
   endtask

   task automatic axi_read(input logic [11:0] a, input logic [31:0] ed, input logic [1:0] er,
                           input int stall);
      bit hs = 1'b0;
      int cnt = 0;
      r_q.push_back({ed, er});
      axi.araddr  = a;
      axi.arvalid = 1'b1;
      if (stall > 0) axi.rready = 1'b0;
      while (!hs && cnt < 30) begin
         @(negedge clk);
         hs = axi.arready;
         @(posedge clk); #1;
         cnt++;
      end
      axi.arvalid = 1'b0;
      check("ar accepted", {31'b0, hs}, 32'd1);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("rvalid held", {31'b0, axi.rvalid}, 32'd1);
         check("rdata held", axi.rdata, ed);
         @(posedge clk); #1;
      end
      axi.rready = 1'b1;
      hs = 1'b0;
      cnt = 0;
      while (!hs && cnt < 30) begin
         @(negedge clk);
         hs = axi.rvalid && axi.rready;
         @(posedge clk); #1;
         cnt++;
      end
      check("r handshake", {31'b0, hs}, 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn      = 1'b0;
      core_done   = 1'b0;
      core_busy   = 1'b0;
      axi.awaddr  = '0;
      axi.awvalid = 1'b0;
      axi.wdata   = '0;
      axi.wstrb   = '0;
      axi.wvalid  = 1'b0;
      axi.bready  = 1'b1;
      axi.araddr  = '0;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b1;
      idle(3);
      @(negedge clk);
      check("reset handshake outs",
            {27'b0, axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}, 32'd0);
      check("reset resp/start", {27'b0, axi.bresp, axi.rresp, start}, 32'd0);
      check("reset rdata", axi.rdata, 32'd0);
      check("reset regs", command | addr_table_base_i | argc_i | addr_table_base_o | argc_o,
            32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      idle(2);

      // Register write / readback
      axi_write(12'h004, 32'h0000_0200, 4'hF, 2'b00, 0, 1'b0);
      axi_write(12'h008, 32'h0000_0003, 4'hF, 2'b00, 0, 1'b0);
      axi_write(12'h00C, 32'h0000_0300, 4'hF, 2'b00, 0, 1'b0);
      axi_write(12'h010, 32'h0000_0001, 4'hF, 2'b00, 0, 1'b0);
      axi_read(12'h004, 32'h0000_0200, 2'b00, 0);
      axi_read(12'h008, 32'h0000_0003, 2'b00, 0);
      axi_read(12'h00C, 32'h0000_0300, 2'b00, 0);
      axi_read(12'h010, 32'h0000_0001, 2'b00, 0);
      axi_read(12'h000, 32'h0000_0000, 2'b00, 0);
      check("out base_i", addr_table_base_i, 32'h200);
      check("out argc_i", argc_i, 32'h3);
      check("out base_o", addr_table_base_o, 32'h300);
      check("out argc_o", argc_o, 32'h1);

      // Start pulse, busy, done capture and clear
      start_cnt = 0;
      axi_write(12'h000, 32'h0000_0001, 4'hF, 2'b00, 0, 1'b0);
      idle(3);
      check("start pulse count", start_cnt, 32'd1);
      check("command after start", command, 32'h1);
      core_busy = 1'b1;
      axi_read(12'h000, 32'h0000_0002, 2'b00, 0);
      core_busy = 1'b0;
      core_done = 1'b1;
      idle(1);
      core_done = 1'b0;
      axi_read(12'h000, 32'h0000_0001, 2'b00, 0);
      axi_write(12'h000, 32'h0000_0001, 4'hF, 2'b00, 0, 1'b0);
      idle(2);
      check("no pulse on 1 over 1", start_cnt, 32'd1);
      axi_read(12'h000, 32'h0000_0001, 2'b00, 0);
      axi_write(12'h000, 32'h0000_0000, 4'hF, 2'b00, 0, 1'b0);
      axi_read(12'h000, 32'h0000_0000, 2'b00, 0);
      check("command cleared", command, 32'h0);

      // W ahead of AW, then same-cycle AW/W
      axi_write(12'h008, 32'h0000_0055, 4'hF, 2'b00, 3, 1'b0);
      axi_read(12'h008, 32'h0000_0055, 2'b00, 0);
      axi_write(12'h008, 32'h0000_0003, 4'hF, 2'b00, 0, 1'b0);
      axi_read(12'h008, 32'h0000_0003, 2'b00, 0);

      // B back-pressure: a new AW must not be accepted while bvalid waits
      axi_write(12'h010, 32'h0000_001F, 4'hF, 2'b00, 0, 1'b1);
      axi.awaddr  = 12'h004;
      axi.awvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bvalid held", {31'b0, axi.bvalid}, 32'd1);
         check("awready low in resp", {31'b0, axi.awready}, 32'd0);
         @(posedge clk); #1;
      end
      axi.awvalid = 1'b0;
      axi.bready  = 1'b1;
      wait_b();
      axi_read(12'h010, 32'h0000_001F, 2'b00, 0);
      axi_read(12'h004, 32'h0000_0200, 2'b00, 0);

      // Byte strobe merge
      axi_write(12'h008, 32'hAABB_CCDD, 4'b0010, 2'b00, 0, 1'b0);
      axi_read(12'h008, 32'h0000_CC03, 2'b00, 0);

      // Unmapped offsets and R back-pressure
      axi_write(12'h014, 32'hDEAD_BEEF, 4'hF, 2'b10, 0, 1'b0);
      axi_read(12'h014, 32'h0000_0000, 2'b10, 4);
      axi_read(12'h01C, 32'h0000_0000, 2'b10, 0);
      axi_read(12'h804, 32'h0000_0000, 2'b10, 0);
      axi_read(12'h00B, 32'h0000_CC03, 2'b00, 0);
      axi_read(12'h004, 32'h0000_0200, 2'b00, 3);
      axi_read(12'h00C, 32'h0000_0300, 2'b00, 0);
      axi_read(12'h010, 32'h0000_001F, 2'b00, 0);
      axi_read(12'h000, 32'h0000_0000, 2'b00, 0);

      // Reset while a write response is pending
      axi_write(12'h00C, 32'h0000_0300, 4'hF, 2'b00, 0, 1'b1);
      @(negedge clk);
      check("bvalid before reset", {31'b0, axi.bvalid}, 32'd1);
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      b_q.delete();
      axi.bready = 1'b1;
      @(negedge clk);
      check("bvalid after reset", {31'b0, axi.bvalid}, 32'd0);
      check("awready after reset", {31'b0, axi.awready}, 32'd0);
      check("regs after reset", command | addr_table_base_i | argc_i | addr_table_base_o | argc_o,
            32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      idle(2);
      axi_read(12'h000, 32'h0000_0000, 2'b00, 0);
      axi_read(12'h004, 32'h0000_0000, 2'b00, 0);
      axi_read(12'h008, 32'h0000_0000, 2'b00, 0);
      axi_read(12'h00C, 32'h0000_0000, 2'b00, 0);
      axi_read(12'h010, 32'h0000_0000, 2'b00, 0);

      idle(3);
      check("b queue drained", b_q.size(), 32'd0);
      check("r queue drained", r_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
